// File: rtl/tff_bank_pkg.sv
// Shared types and helpers for the T flip-flop bank arbiter: FSM states,
// derived index widths and the round-robin pick.
package tff_bank_pkg;

  typedef enum logic [1:0] {IDLE, RUN, ACK} state_t;

  localparam int unsigned RR_MAX = 8;

  function automatic int unsigned clog2_min1(int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned idx_w(int unsigned width);
    return clog2_min1(width);
  endfunction

  function automatic int unsigned gid_w(int unsigned nreq);
    return clog2_min1(nreq);
  endfunction

  // First asserted request at or after ptr, wrapping modulo n (n <= RR_MAX).
  function automatic int unsigned rr_pick(logic [RR_MAX-1:0] req, int unsigned ptr,
                                          int unsigned n);
    int unsigned sel;
    int unsigned k;
    logic        found;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      k = (ptr + i >= n) ? ptr + i - n : ptr + i;
      if (i < n && !found && req[k[2:0]]) begin
        sel   = k;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH T flip-flops; a bit toggles on an edge where en & t, else holds.
module tff_bank #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] en,
  input  logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  logic [WIDTH-1:0] q_nxt;

  assign q_nxt = q ^ (en & t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q  <= '0;
      qn <= '1;
    end else begin
      q  <= q_nxt;
      qn <= ~q_nxt;
    end
  end

endmodule

// File: rtl/tff_bank_arbiter.sv
// Round-robin arbiter sequencing toggle requests onto a shared T flip-flop bank.
// Optional synchronous bank clear in IDLE when TFF_BANK_CLEAR_EN is defined.
module tff_bank_arbiter
  import tff_bank_pkg::*;
#(
  parameter  int unsigned NREQ  = 4,
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned CNT_W = 4,
  localparam int unsigned IDX_W = idx_w(WIDTH),
  localparam int unsigned GID_W = gid_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef TFF_BANK_CLEAR_EN
  input  logic                  clr,
`endif
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*IDX_W-1:0] req_idx,
  input  logic [NREQ*CNT_W-1:0] req_cnt,
  output logic [NREQ-1:0]       ack,
  output logic                  busy,
  output logic [GID_W-1:0]      grant_id,
  output logic [WIDTH-1:0]      q,
  output logic [WIDTH-1:0]      qn
);

  state_t           state, state_nxt;
  logic [GID_W-1:0] ptr, ptr_nxt, gid_nxt;
  logic [IDX_W-1:0] lat_idx, lat_idx_nxt;
  logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic [NREQ-1:0]  ack_nxt;
  logic             busy_nxt;
  logic [WIDTH-1:0] en_c, t_c;
  logic [GID_W-1:0] pick_c;
  logic [IDX_W-1:0] pick_idx_c;
  logic [CNT_W-1:0] pick_cnt_c;
  logic             in_range_c;
  logic             clr_c;

`ifdef TFF_BANK_CLEAR_EN
  assign clr_c = clr;
`else
  assign clr_c = 1'b0;
`endif

  assign pick_c     = GID_W'(rr_pick(8'(req), 32'(ptr), NREQ));
  assign pick_idx_c = req_idx[pick_c*IDX_W +: IDX_W];
  assign pick_cnt_c = req_cnt[pick_c*CNT_W +: CNT_W];
  assign in_range_c = (32'(pick_idx_c) < WIDTH);

  // State and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      grant_id <= '0;
      lat_idx  <= '0;
      lat_cnt  <= '0;
      ack      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= gid_nxt;
      lat_idx  <= lat_idx_nxt;
      lat_cnt  <= lat_cnt_nxt;
      ack      <= ack_nxt;
      busy     <= busy_nxt;
    end
  end

  // Next-state: arbitration in IDLE, countdown in RUN, pointer advance in ACK.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    gid_nxt     = grant_id;
    lat_idx_nxt = lat_idx;
    lat_cnt_nxt = lat_cnt;
    case (state)
      IDLE: begin
        if (!clr_c && |req) begin
          gid_nxt     = pick_c;
          lat_idx_nxt = pick_idx_c;
          lat_cnt_nxt = pick_cnt_c;
          state_nxt   = (pick_cnt_c != '0 && in_range_c) ? RUN : ACK;
        end
      end
      RUN: begin
        lat_cnt_nxt = lat_cnt - CNT_W'(1);
        if (lat_cnt == CNT_W'(1)) state_nxt = ACK;
      end
      ACK: begin
        ptr_nxt   = (grant_id == GID_W'(NREQ - 1)) ? '0 : grant_id + GID_W'(1);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: one-hot toggle during RUN, clear-by-toggle of set bits, ack/busy.
  always_comb begin
    en_c     = '0;
    t_c      = '0;
    ack_nxt  = '0;
    busy_nxt = (state_nxt != IDLE);
    if (state == RUN) begin
      en_c = WIDTH'(1) << lat_idx;
      t_c  = WIDTH'(1) << lat_idx;
    end else if (state == IDLE && clr_c) begin
      en_c = '1;
      t_c  = q;
    end
    if (state_nxt == ACK) ack_nxt = NREQ'(1) << gid_nxt;
  end

  tff_bank #(.WIDTH(WIDTH)) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en_c),
    .t    (t_c),
    .q    (q),
    .qn   (qn)
  );

endmodule
